// File: rtl/i2c_arbiter_if.sv
// ----------------------------------------------------------------------------
// i2c_arbiter_if
// Bundle between the requesters, the arbiter and a single i2c_master.
//   req/req_addr/req_len/req_data : per-requester request, {addr[6:0],rw},
//                                   byte count and current data byte
//   gnt/data_next/done/err        : per-requester one-hot status back to users
//   m_ena/m_addr/m_rw/m_data_wr   : command side of the i2c_master
//   m_busy/m_load                 : status side of the i2c_master
// Modport slave is taken by the arbiter, modport master by whoever drives
// the requests and models the i2c_master.
// ----------------------------------------------------------------------------
interface i2c_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_addr;
   logic [4*NUM_REQ-1:0] req_len;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   data_next;
   logic [NUM_REQ-1:0]   done;
   logic [NUM_REQ-1:0]   err;
   logic                 m_ena;
   logic [6:0]           m_addr;
   logic                 m_rw;
   logic [7:0]           m_data_wr;
   logic                 m_busy;
   logic                 m_load;

   modport slave (
      input  req, req_addr, req_len, req_data, m_busy, m_load,
      output gnt, data_next, done, err, m_ena, m_addr, m_rw, m_data_wr
   );

   modport master (
      output req, req_addr, req_len, req_data, m_busy, m_load,
      input  gnt, data_next, done, err, m_ena, m_addr, m_rw, m_data_wr
   );
endinterface

// File: rtl/i2c_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_arbiter
// Shares one i2c_master between NUM_REQ requesters. A winner is picked
// round-robin in IDLE, its address/rw/length are latched, and the master is
// driven through the byte sequence. Each time the master latches a byte
// (rising m_load) the granted requester gets a data_next pulse so it can
// present the following byte. Every busy state is guarded by a cycle
// counter; hitting TIMEOUT aborts the transfer with err.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : i2c_arbiter_if.slave (requests, status, i2c_master signals)
// ----------------------------------------------------------------------------
module i2c_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic          clk,
   input  logic          rst,
   i2c_arbiter_if.slave  bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   typedef enum logic [2:0] {
      IDLE, START, WAIT, LOADED, WAIT_LAST, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [IW-1:0]      last_q, last_d;
   logic [3:0]         len_q, len_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [CW-1:0]      tcnt_q, tcnt_d;
   logic               err_q, err_d;
   logic [6:0]         addr_q, addr_d;
   logic               rw_q, rw_d;
   logic [7:0]         data_q, data_d;
   logic [NUM_REQ-1:0] dn_q, dn_d;
   logic               load_q;

   logic [7:0]         slot_addr [NUM_REQ];
   logic [3:0]         slot_len  [NUM_REQ];
   logic [7:0]         slot_data [NUM_REQ];
   logic [NUM_REQ-1:0] gnt_w;

   logic               found;
   logic [IW-1:0]      win;
   logic [IW:0]        cand;
   logic               timeout;
   logic               load_rise;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
         assign slot_addr[gi] = bus.req_addr[8*gi +: 8];
         assign slot_len[gi]  = bus.req_len[4*gi +: 4];
         assign slot_data[gi] = bus.req_data[8*gi +: 8];
         assign gnt_w[gi]     = (state_q != IDLE) && (idx_q == IW'(gi));
         assign bus.done[gi]  = gnt_w[gi] && (state_q == DONE);
         assign bus.err[gi]   = gnt_w[gi] && (state_q == DONE) && err_q;
      end
   endgenerate

   assign bus.gnt       = gnt_w;
   assign bus.data_next = dn_q;
   assign bus.m_ena     = (state_q == START) || (state_q == WAIT) || (state_q == LOADED);
   assign bus.m_addr    = addr_q;
   assign bus.m_rw      = rw_q;
   assign bus.m_data_wr = data_q;

   // Round-robin search: first requester at or after last_grant+1, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_q} + (IW+1)'(k);
         if (cand >= NR) cand = cand - NR;
         if (!found && bus.req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      data_d    = data_q;
      dn_d      = '0;
      tcnt_d    = '0;
      timeout   = (tcnt_q == CW'(TIMEOUT - 1));
      load_rise = bus.m_load && !load_q;

      // Data byte tracks the granted slot every cycle while granted.
      if (state_q != IDLE) data_d = slot_data[idx_q];

      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (found) begin
               idx_d  = win;
               addr_d = slot_addr[win][7:1];
               rw_d   = slot_addr[win][0];
               len_d  = slot_len[win];
               cnt_d  = 4'd1;
               data_d = slot_data[win];
               // A zero-length request never touches the bus.
               if (slot_len[win] == 4'd0) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = START;
               end
            end
         end
         START: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (bus.m_busy) begin
               state_d = (len_q == 4'd1) ? WAIT_LAST : WAIT;
            end
         end
         WAIT: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (load_rise) begin
               cnt_d   = cnt_q + 4'd1;
               dn_d    = ONE << idx_q;
               state_d = LOADED;
            end
         end
         LOADED: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (!bus.m_load) begin
               state_d = (cnt_q == len_q) ? WAIT_LAST : WAIT;
            end
         end
         WAIT_LAST: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (!bus.m_busy) begin
               state_d = DONE;
            end
         end
         DONE: begin
            last_d  = idx_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Dwell counter restarts on every state change; only busy states count.
      if (state_d == state_q && state_q != IDLE && state_q != DONE)
         tcnt_d = tcnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         len_q   <= '0;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         data_q  <= '0;
         dn_q    <= '0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         data_q  <= data_d;
         dn_q    <= dn_d;
         load_q  <= bus.m_load;
      end
   end
endmodule

// File: tb/tb_i2c_arbiter.sv
// ----------------------------------------------------------------------------
// tb_i2c_arbiter
// Drives two requesters and a behavioural i2c_master, and scores every
// transaction against a transaction-level model: the expected winner comes
// from a round-robin search over the request vector, and the expected bytes,
// data_next count and err flag come from the requester's descriptor.
// All stimulus and observation happen on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_i2c_arbiter;
   localparam int N   = 2;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   i2c_arbiter_if #(.NUM_REQ(N)) bus ();
   i2c_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // requester descriptors
   logic [7:0] r_addr  [N];
   logic [3:0] r_len   [N];
   logic [7:0] r_bytes [N][16];
   int         r_ptr   [N];
   bit         active  [N];
   logic [N-1:0] req_v;

   // master model
   int   mphase, mtimer;
   logic busy_v, load_v;
   bit   no_busy;
   logic [7:0] cap_q[$];

   // scoreboard
   int  mode;          // 0 directed, 1 hold/rearm, 2 random
   int  hold_left;
   int  last_model;
   int  cur;
   bit  in_txn;
   int  ena_cyc, dn_cnt, gnt_cyc, cyc, viol, done_events;
   bit  follow_pend;
   logic [7:0] follow_byte;
   int  grant_log[$];
   int  res_idx, res_dn, res_ena;
   bit  res_err, res_rw;
   logic [6:0] res_addr;
   logic [7:0] res_bytes[$];

   typedef struct {
      int         slot;
      logic [7:0] addr;
      logic [3:0] len;
      logic [7:0] b0, b1, b2;
      bit         nobusy;
      logic [6:0] e_addr;
      bit         e_rw;
      bit         e_err;
      int         e_dn;
      int         e_ena;   // -1: not checked
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int rr(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive_bus();
      bus.req      = req_v;
      bus.req_addr = {r_addr[1], r_addr[0]};
      bus.req_len  = {r_len[1], r_len[0]};
      bus.req_data = {r_bytes[1][r_ptr[1]], r_bytes[0][r_ptr[0]]};
      bus.m_busy   = busy_v;
      bus.m_load   = load_v;
   endtask

   task automatic reset_env();
      mphase = 0; mtimer = 0; busy_v = 1'b0; load_v = 1'b0;
      in_txn = 1'b0; follow_pend = 1'b0; last_model = N - 1;
      req_v = '0;
      for (int i = 0; i < N; i++) begin
         active[i] = 1'b0;
         r_ptr[i]  = 0;
      end
   endtask

   task automatic rearm(input int i, input int lo, input int hi);
      r_len[i]  = 4'($urandom_range(hi, lo));
      r_addr[i] = 8'($urandom);
      for (int b = 0; b < 16; b++) r_bytes[i][b] = 8'($urandom);
      r_ptr[i]  = 0;
      active[i] = 1'b1;
      req_v[i]  = 1'b1;
   endtask

   task automatic monitor();
      int  ex;
      bit  exp_err;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.data_next) || !$onehot0(bus.done) ||
          (((bus.data_next | bus.done | bus.err) & ~bus.gnt) != '0) ||
          ((bus.err & ~bus.done) != '0) || (bus.m_ena && bus.gnt == '0))
         viol++;

      if (!in_txn && bus.gnt != '0) begin
         ex = rr(last_model, req_v);
         check("grant_index", {30'd0, bus.gnt}, (ex < 0) ? 32'd0 : (32'd1 << ex));
         if (ex < 0) ex = 0;
         check("m_addr", {25'd0, bus.m_addr}, {25'd0, r_addr[ex][7:1]});
         check("m_rw", {31'd0, bus.m_rw}, {31'd0, r_addr[ex][0]});
         cur = ex; in_txn = 1'b1; ena_cyc = 0; dn_cnt = 0; gnt_cyc = cyc;
         cap_q.delete();
         res_addr = bus.m_addr; res_rw = bus.m_rw;
         grant_log.push_back(ex);
         if (mode == 2 && $urandom_range(1, 0) == 1) req_v[cur] = 1'b0;
      end

      if (in_txn) begin
         if (bus.m_ena) ena_cyc++;
         if (bus.data_next != '0) dn_cnt++;
         if (follow_pend) begin
            check("data_wr_follow", {24'd0, bus.m_data_wr}, {24'd0, follow_byte});
            follow_pend = 1'b0;
         end
         if (bus.data_next[cur]) begin
            if (r_ptr[cur] < 15) r_ptr[cur]++;
            follow_pend = 1'b1;
            follow_byte = r_bytes[cur][r_ptr[cur]];
         end
         if (bus.done != '0) begin
            exp_err = (r_len[cur] == 4'd0) || no_busy;
            check("done_index", {30'd0, bus.done}, 32'd1 << cur);
            check("err", {30'd0, bus.err}, exp_err ? (32'd1 << cur) : 32'd0);
            check("protocol", viol, 0);
            if (r_len[cur] == 4'd0) begin
               check("len0_ena", ena_cyc, 0);
               check("len0_latency", {31'd0, (cyc - gnt_cyc) <= 2}, 1);
            end else if (no_busy) begin
               check("timeout_ena_cycles", ena_cyc, TMO);
            end else begin
               check("data_next_count", dn_cnt, int'(r_len[cur]) - 1);
               check("byte_count", cap_q.size(), int'(r_len[cur]));
               for (int b = 0; b < cap_q.size() && b < int'(r_len[cur]); b++)
                  check("byte", {24'd0, cap_q[b]}, {24'd0, r_bytes[cur][b]});
            end
            res_idx = cur; res_err = (bus.err != '0); res_dn = dn_cnt; res_ena = ena_cyc;
            res_bytes = cap_q;
            $display("txn %0d: req %0d addr %02h len %0d err %0d data_next %0d", done_events,
                     cur, r_addr[cur], r_len[cur], res_err, dn_cnt);
            last_model  = cur;
            in_txn      = 1'b0;
            follow_pend = 1'b0;
            done_events++;
            active[cur] = 1'b0;
            r_ptr[cur]  = 0;
            if (mode == 1 && hold_left > 0) begin
               hold_left--;
               rearm(cur, 1, 2);
            end else begin
               req_v[cur] = 1'b0;
            end
         end
      end
   endtask

   task automatic master_step();
      if (no_busy) begin
         mphase = 0; busy_v = 1'b0; load_v = 1'b0;
      end else begin
         case (mphase)
            0: if (bus.m_ena) begin mphase = 1; mtimer = 1; end
            1: begin
               if (!bus.m_ena) mphase = 0;
               else begin
                  mtimer++;
                  if (mtimer == 3) begin busy_v = 1'b1; mphase = 2; mtimer = 0; end
               end
            end
            2: begin
               mtimer++;
               if (mtimer == 6) begin
                  cap_q.push_back(bus.m_data_wr);
                  mtimer = 0;
                  if (bus.m_ena) begin load_v = 1'b1; mphase = 3; end
                  else begin busy_v = 1'b0; mphase = 0; end
               end
            end
            default: begin
               mtimer++;
               if (mtimer == 2) begin load_v = 1'b0; mphase = 2; mtimer = 0; end
            end
         endcase
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (rst) begin
         reset_env();
      end else begin
         monitor();
         master_step();
         if (mode == 2)
            for (int i = 0; i < N; i++)
               if (!active[i] && $urandom_range(3, 0) == 0) rearm(i, 0, 4);
      end
      drive_bus();
   endtask

   task automatic wait_done(input int n, input int budget, input string name);
      int target;
      int t;
      target = done_events + n;
      t = 0;
      while (done_events < target && t < budget) begin
         tick();
         t++;
      end
      check({name, "_completed"}, {31'd0, done_events >= target}, 1);
   endtask

   initial begin
      logic [7:0] eb [3];
      int stray;
      int t;

      vecs[0] = '{0, 8'hE8, 4'd1, 8'h04, 8'h00, 8'h00, 1'b0, 7'h74, 1'b0, 1'b0, 0, -1};
      vecs[1] = '{1, 8'h20, 4'd3, 8'h30, 8'h85, 8'h00, 1'b0, 7'h10, 1'b0, 1'b0, 2, -1};
      vecs[2] = '{0, 8'h42, 4'd0, 8'hAA, 8'h00, 8'h00, 1'b0, 7'h21, 1'b0, 1'b1, 0, 0};
      vecs[3] = '{0, 8'h90, 4'd2, 8'h11, 8'h22, 8'h00, 1'b1, 7'h48, 1'b0, 1'b1, 0, TMO};
      vecs[4] = '{0, 8'h3C, 4'd1, 8'h5A, 8'h00, 8'h00, 1'b0, 7'h1E, 1'b0, 1'b0, 0, -1};
      vecs[5] = '{1, 8'hA5, 4'd2, 8'hC3, 8'h7E, 8'h00, 1'b0, 7'h52, 1'b1, 1'b0, 1, -1};

      rst = 1'b1;
      mode = 0; hold_left = 0; no_busy = 1'b0; cyc = 0; viol = 0; done_events = 0;
      for (int i = 0; i < N; i++) begin
         r_addr[i] = '0; r_len[i] = '0;
         for (int b = 0; b < 16; b++) r_bytes[i][b] = '0;
      end
      reset_env();
      drive_bus();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", {30'd0, bus.gnt}, 0);
      check("rst_m_ena", {31'd0, bus.m_ena}, 0);
      check("rst_done_err", {28'd0, bus.done, bus.err}, 0);
      check("rst_data_next", {30'd0, bus.data_next}, 0);
      check("rst_m_addr_rw", {24'd0, bus.m_addr, bus.m_rw}, 0);
      check("rst_m_data_wr", {24'd0, bus.m_data_wr}, 0);
      @(negedge clk);
      rst = 1'b0;

      // table-driven single transactions
      for (int v = 0; v < 6; v++) begin
         int s;
         s = vecs[v].slot;
         r_addr[s] = vecs[v].addr;
         r_len[s]  = vecs[v].len;
         r_bytes[s][0] = vecs[v].b0;
         r_bytes[s][1] = vecs[v].b1;
         r_bytes[s][2] = vecs[v].b2;
         eb[0] = vecs[v].b0; eb[1] = vecs[v].b1; eb[2] = vecs[v].b2;
         r_ptr[s] = 0; active[s] = 1'b1; req_v[s] = 1'b1;
         no_busy = vecs[v].nobusy;
         drive_bus();
         wait_done(1, 400, "vec");
         check("vec_grant", res_idx, s);
         check("vec_m_addr", {25'd0, res_addr}, {25'd0, vecs[v].e_addr});
         check("vec_m_rw", {31'd0, res_rw}, {31'd0, vecs[v].e_rw});
         check("vec_err", {31'd0, res_err}, {31'd0, vecs[v].e_err});
         check("vec_data_next", res_dn, vecs[v].e_dn);
         if (vecs[v].e_ena >= 0) check("vec_ena_cycles", res_ena, vecs[v].e_ena);
         if (!vecs[v].nobusy && vecs[v].len != 4'd0) begin
            check("vec_byte_count", res_bytes.size(), int'(vecs[v].len));
            for (int b = 0; b < res_bytes.size() && b < 3; b++)
               check("vec_byte", {24'd0, res_bytes[b]}, {24'd0, eb[b]});
         end
         no_busy = 1'b0;
         repeat (3) tick();
      end

      // contention: both held for four transactions, last grant was 1
      grant_log.delete();
      mode = 1; hold_left = 2;
      rearm(0, 1, 2);
      rearm(1, 1, 2);
      drive_bus();
      wait_done(4, 800, "contention");
      check("contention_count", grant_log.size(), 4);
      for (int k = 0; k < grant_log.size() && k < 4; k++)
         check("contention_order", grant_log[k], k % 2);
      mode = 0;
      repeat (3) tick();

      // leave last grant at 0, then abort a len-3 transfer on requester 1
      rearm(0, 1, 1);
      drive_bus();
      wait_done(1, 400, "pre_reset");
      repeat (2) tick();
      rearm(1, 3, 3);
      for (int b = 0; b < 3; b++) r_bytes[1][b] = 8'h80 | 8'(b);
      drive_bus();
      t = 0;
      while (!(mphase == 2 && mtimer >= 2) && t < 200) begin
         tick();
         t++;
      end
      check("reset_reached_wait", {31'd0, bus.m_ena && mphase == 2}, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_m_ena", {31'd0, bus.m_ena}, 0);
      check("arst_gnt", {30'd0, bus.gnt}, 0);
      check("arst_status", {26'd0, bus.data_next, bus.done, bus.err}, 0);
      check("arst_m_addr_rw", {24'd0, bus.m_addr, bus.m_rw}, 0);
      check("arst_m_data_wr", {24'd0, bus.m_data_wr}, 0);
      tick();
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.done != '0) stray++;
      end
      check("no_done_after_reset", stray, 0);
      grant_log.delete();
      rearm(0, 1, 2);
      rearm(1, 1, 2);
      drive_bus();
      wait_done(2, 800, "post_reset");
      check("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

      // randomized traffic
      mode = 2;
      wait_done(40, 12000, "random");
      mode = 0;
      t = 0;
      while ((active[0] || active[1] || in_txn) && t < 2000) begin
         tick();
         t++;
      end
      check("drained", {31'd0, active[0] || active[1] || in_txn}, 0);
      check("protocol_final", viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 1_000_000, maximum clk cycles spent in any single state before abort.
REQ-003 The block SHALL use one clock and an asynchronous active-high reset, with ports:
  clk  input  1  system clock, all logic on rising edge
  rst  input  1  asynchronous active-high reset
  req  input  NUM_REQ  per-requester transaction request (level)
  req_addr  input  8*NUM_REQ  per-requester {dev_addr[6:0], rw}, slot i at [8i+7:8i]
  req_len  input  4*NUM_REQ  per-requester byte count, slot i at [4i+3:4i]
  req_data  input  8*NUM_REQ  per-requester current data byte
  gnt  output  NUM_REQ  one-hot grant, high for the whole transaction
  data_next  output  NUM_REQ  one-cycle pulse; requester presents next byte
  done  output  NUM_REQ  one-cycle completion pulse
  err  output  NUM_REQ  one-cycle error pulse, coincident with done
  m_ena  output  1  i2c_master ena
  m_addr  output  7  i2c_master addr
  m_rw  output  1  i2c_master rw
  m_data_wr  output  8  i2c_master data_wr
  m_busy  input  1  i2c_master busy
  m_load  input  1  i2c_master load (byte latched)

Function
REQ-004 The FSM SHALL have states IDLE, START, WAIT, LOADED, WAIT_LAST and DONE.
REQ-005 IDLE: m_ena=0 and gnt=0; when any req bit is high, the block SHALL pick the winner round-robin starting at last_grant+1 (mod NUM_REQ), latch index, req_addr and req_len, then go to START.
REQ-006 A latched req_len of 0 SHALL cause a transition to DONE with err set, and m_ena SHALL never assert.
REQ-007 START: m_ena=1; on m_busy=1, the FSM SHALL go to WAIT_LAST if len==1, else to WAIT.
REQ-008 While gnt is active, m_data_wr SHALL be a register loaded every cycle from the granted slot of req_data (1-cycle latency); m_addr and m_rw SHALL come from the latched copy.
REQ-009 The byte counter SHALL reset to 1 on grant; in WAIT, a rising edge of m_load (m_load=1, previous cycle 0) SHALL increment the counter, pulse data_next[g] and move to LOADED.
REQ-010 LOADED: when m_load=0, the FSM SHALL go to WAIT_LAST if count==len, else to WAIT.
REQ-011 WAIT_LAST: m_ena=0; on m_busy=0, the FSM SHALL go to DONE.
REQ-012 DONE: the block SHALL pulse done[g] (and err[g] if flagged) for one cycle, set last_grant=g, clear gnt and return to IDLE; the next arbitration SHALL occur no earlier than the following cycle.
REQ-013 A per-state cycle counter SHALL clear on every state change; reaching TIMEOUT in START, WAIT, LOADED or WAIT_LAST SHALL force m_ena=0, set err and go to DONE.
REQ-014 req SHALL be sampled only in IDLE; deasserting req mid-transaction SHALL NOT abort it, and requests arriving mid-transaction SHALL wait.
REQ-015 Simultaneous requests SHALL be granted strictly round-robin, and a requester holding req continuously SHALL NOT be granted twice in a row while another requester is pending.
REQ-016 rw=1 SHALL be passed through unchanged with identical byte counting; read data is not routed.
REQ-017 gnt, data_next, done and err SHALL be mutually consistent: at most one bit set per vector, and data_next/done/err SHALL be set only on the granted index.

Reset
REQ-018 On rst=1, the block SHALL asynchronously set state=IDLE, m_ena=0, gnt=0, data_next=0, done=0, err=0, m_addr=0, m_rw=0, m_data_wr=0, counters=0 and last_grant=NUM_REQ-1, so that requester 0 has first priority.
REQ-019 A reset asserted mid-transaction SHALL drop m_ena immediately, and no done pulse SHALL be issued for the aborted transaction.

Verification
REQ-020 Single write: req[0], addr 8'hE8, len 1, data 8'h04, with the master model asserting busy 3 cycles after ena -> m_addr=7'h74, m_rw=0, m_data_wr=8'h04, m_ena falls in WAIT_LAST, one done[0] pulse, err=0.
REQ-021 Multi-byte: req[1], addr 8'h20, len 3, bytes 8'h30, 8'h85, 8'h00 -> exactly 2 data_next[1] pulses, m_data_wr follows each byte within 1 cycle, then done[1].
REQ-022 Contention: req=2'b11 held continuously for 4 transactions -> grant order 0,1,0,1, with gnt never two-hot.
REQ-023 Zero length: req[0], len 0 -> done[0] and err[0] within 3 cycles, m_ena never high.
REQ-024 Timeout: TIMEOUT=64, master model never asserts busy -> m_ena low and done[0]+err[0] after 64 cycles in START, then the next request is served normally.
REQ-025 Reset: rst pulsed while in WAIT of a len-3 transfer -> all outputs 0 in the same cycle, no done pulse, and the next grant goes to requester 0.
